// File: rtl/impact_sram_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : impact_sram_sequencer_if
// Brief   : Host request/response and SRAM-head bus bundle for the sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface impact_sram_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [1:0] req_bank;
  logic [9:0] req_word;
  logic [1:0] req_byte;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       sram_pre;
  logic       sram_read_en;
  logic       sram_write_en;
  logic [1:0] sram_bank_sel;
  logic [9:0] sram_word_sel;
  logic [1:0] sram_byte_sel;
  logic [7:0] sram_data_in;
  logic [7:0] sram_data_out;

  // Host plus SRAM-head side
  modport master (
    output req_valid, req_write, req_bank, req_word, req_byte, req_wdata,
    output sram_data_out,
    input  req_ready, rsp_valid, rsp_rdata,
    input  sram_pre, sram_read_en, sram_write_en,
    input  sram_bank_sel, sram_word_sel, sram_byte_sel, sram_data_in
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_write, req_bank, req_word, req_byte, req_wdata,
    input  sram_data_out,
    output req_ready, rsp_valid, rsp_rdata,
    output sram_pre, sram_read_en, sram_write_en,
    output sram_bank_sel, sram_word_sel, sram_byte_sel, sram_data_in
  );
endinterface
`default_nettype wire

// File: rtl/impact_sram_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : impact_sram_sequencer
// Brief   : Byte read/write sequencer: PRECHARGE -> ACCESS -> RECOVER phases.
//           Optional read/write statistics counters with IMPACT_SEQ_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module impact_sram_sequencer #(
  parameter int unsigned PRE_CYCLES = 2,
  parameter int unsigned ACC_CYCLES = 3
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  impact_sram_sequencer_if.slave      bus
`ifdef IMPACT_SEQ_STATS_EN
  ,
  output logic [15:0]                 rd_count,
  output logic [15:0]                 wr_count
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRECHARGE = 2'd1,
    ACCESS    = 2'd2,
    RECOVER   = 2'd3
  } state_t;

  localparam logic [3:0] c_PRE_LOAD = 4'(PRE_CYCLES - 1);
  localparam logic [3:0] c_ACC_LOAD = 4'(ACC_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        ready_q;
  logic        pre_q;
  logic        rd_en_q;
  logic        wr_en_q;
  logic        rsp_valid_q;
  logic [7:0]  rdata_q;
  logic        write_q;
  logic [1:0]  bank_q;
  logic [9:0]  word_q;
  logic [1:0]  byte_q;
  logic [7:0]  wdata_q;
`ifdef IMPACT_SEQ_STATS_EN
  logic [15:0] rd_count_q;
  logic [15:0] wr_count_q;
`endif

  // Counter holds "cycles remaining minus one" so a phase ends when it reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      ready_q     <= 1'b1;
      pre_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 8'h00;
      write_q     <= 1'b0;
      bank_q      <= 2'd0;
      word_q      <= 10'd0;
      byte_q      <= 2'd0;
      wdata_q     <= 8'h00;
`ifdef IMPACT_SEQ_STATS_EN
      rd_count_q  <= 16'd0;
      wr_count_q  <= 16'd0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid && ready_q) begin
            write_q <= bus.req_write;
            bank_q  <= bus.req_bank;
            word_q  <= bus.req_word;
            byte_q  <= bus.req_byte;
            wdata_q <= bus.req_wdata;
            ready_q <= 1'b0;
            pre_q   <= 1'b1;
            cnt_q   <= c_PRE_LOAD;
            state_q <= PRECHARGE;
          end
        end
        PRECHARGE: begin
          if (cnt_q == 4'd0) begin
            pre_q   <= 1'b0;
            rd_en_q <= ~write_q;
            wr_en_q <= write_q;
            cnt_q   <= c_ACC_LOAD;
            state_q <= ACCESS;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            rsp_valid_q <= 1'b1;
            rdata_q     <= write_q ? 8'h00 : bus.sram_data_out;
            state_q     <= RECOVER;
`ifdef IMPACT_SEQ_STATS_EN
            if (write_q) begin
              if (wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
            end else begin
              if (rd_count_q != 16'hFFFF) rd_count_q <= rd_count_q + 16'd1;
            end
`endif
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RECOVER: begin
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          pre_q       <= 1'b0;
          rd_en_q     <= 1'b0;
          wr_en_q     <= 1'b0;
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready     = ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_rdata     = rdata_q;
  assign bus.sram_pre      = pre_q;
  assign bus.sram_read_en  = rd_en_q;
  assign bus.sram_write_en = wr_en_q;
  assign bus.sram_bank_sel = bank_q;
  assign bus.sram_word_sel = word_q;
  assign bus.sram_byte_sel = byte_q;
  assign bus.sram_data_in  = wdata_q;

`ifdef IMPACT_SEQ_STATS_EN
  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule
`default_nettype wire

// File: doc/impact_sram_sequencer.md
IMPACT_SRAM_SEQUENCER -- requirements
Module: impact_sram_sequencer

Interface
REQ-001 SHALL have parameter PRE_CYCLES, default 2: precharge phase length in clk cycles; legal range 1..15.
REQ-002 SHALL have parameter ACC_CYCLES, default 3: read/write enable phase length in clk cycles; legal range 1..15.
REQ-003 SHALL use one clock and an asynchronous, active-high reset: clk, rst.
REQ-004 clk  input  1  user project clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  host request present.
REQ-007 req_ready  output  1  sequencer can accept a request.
REQ-008 req_write  input  1  1 = byte write, 0 = byte read.
REQ-009 req_bank  input  2  target bank.
REQ-010 req_word  input  10  target word.
REQ-011 req_byte  input  2  target byte within word.
REQ-012 req_wdata  input  8  write byte.
REQ-013 rsp_valid  output  1  one-cycle completion pulse.
REQ-014 rsp_rdata  output  8  read byte; 0 for writes.
REQ-015 sram_pre  output  1  drives PreCharge.
REQ-016 sram_read_en / sram_write_en  output  1 each  drive ReadEnable / WriteEnable.
REQ-017 sram_bank_sel 2, sram_word_sel 10, sram_byte_sel 2, sram_data_in 8  outputs  latched request fields to the SRAM head.
REQ-018 sram_data_out  input  8  byte returned by the SRAM head output mux.

Function
REQ-019 States SHALL be IDLE, PRECHARGE, ACCESS and RECOVER.
REQ-020 req_ready SHALL be 1 only in IDLE; a handshake occurs when req_valid and req_ready are both 1 on a clk edge.
REQ-021 On a handshake, all req_* fields SHALL be latched and the state SHALL move to PRECHARGE.
REQ-022 PRECHARGE SHALL last exactly PRE_CYCLES cycles with sram_pre=1, then move to ACCESS.
REQ-023 ACCESS SHALL last exactly ACC_CYCLES cycles with sram_read_en=1 (read) or sram_write_en=1 (write), then move to RECOVER.
REQ-024 A read SHALL capture sram_data_out into rsp_rdata on the last ACCESS cycle.
REQ-025 RECOVER SHALL last 1 cycle with all strobes low and rsp_valid=1, then return to IDLE.
REQ-026 Latency from the handshake edge to the rsp_valid cycle SHALL be PRE_CYCLES+ACC_CYCLES+1; the next handshake is possible one cycle later.
REQ-027 sram_pre, sram_read_en and sram_write_en SHALL be mutually exclusive in every cycle; all SHALL be registered outputs.
REQ-028 sram_*_sel and sram_data_in SHALL stay stable from PRECHARGE through RECOVER and SHALL hold their last value in IDLE.
REQ-029 Changes on req_* while not in IDLE SHALL be ignored; no request is queued.
REQ-030 The phase counter SHALL be 4 bits, SHALL reload at each phase entry and SHALL never wrap within a phase.

Reset
REQ-031 While rst=1, the state SHALL be IDLE and all strobes, rsp_valid, rsp_rdata and sram_* outputs SHALL be 0; req_ready SHALL be 1 after reset release.
REQ-032 Reset asserted mid-operation SHALL deassert every strobe immediately, without waiting for a clock edge, and the aborted request SHALL produce no rsp_valid.

Configuration
REQ-033 With IMPACT_SEQ_STATS_EN defined, outputs rd_count[15:0] and wr_count[15:0] SHALL exist, increment on each completed read or write respectively (in the RECOVER cycle), saturate at 16'hFFFF and reset to 0.
REQ-034 Without IMPACT_SEQ_STATS_EN, those ports and their counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 Default parameters: write bank 1, word 10'h155, byte 2, data 8'hA5 -> sram_pre high in cycles 1-2, sram_write_en high in cycles 3-5, rsp_valid in cycle 6, rsp_rdata=0.
REQ-036 Read with sram_data_out=8'h3C during ACCESS -> rsp_rdata=8'h3C with rsp_valid in cycle 6; req_ready=1 in cycle 7.
REQ-037 Hold req_valid continuously with back-to-back requests -> handshakes 7 cycles apart, and strobes never overlap.
REQ-038 Assert rst in cycle 4 of a read -> strobes drop asynchronously, no rsp_valid, and IDLE with req_ready=1 after release.
REQ-039 PRE_CYCLES=1, ACC_CYCLES=15 -> rsp_valid in cycle 17; change req_word during ACCESS -> sram_word_sel unchanged.
REQ-040 With IMPACT_SEQ_STATS_EN: 3 reads and 2 writes -> rd_count=3, wr_count=2; force wr_count=16'hFFFF, then perform a write -> wr_count stays 16'hFFFF.
